// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types for the gshare predictor: 2-bit direction counter encoding and its
// saturating update rule.
package branch_predictor_gshare_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_RESET = WNT;

    function automatic bp_ctr_t ctr_step(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t result;
        result = ctr;
        if (taken && ctr != ST) begin
            result = bp_ctr_t'(ctr + 2'd1);
        end else if (!taken && ctr != SNT) begin
            result = bp_ctr_t'(ctr - 2'd1);
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_gshare_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered write,
// valid bits cleared by reset so stale tags/targets are never reported as hits.
module branch_predictor_gshare_btb #(
    parameter int BTB_IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] target,
    output logic        is_jal,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_target,
    input  logic        wr_is_jal
);

    localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W       = 32 - BTB_IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]       tag_mem    [BTB_ENTRIES];
    logic [31:0]            target_mem [BTB_ENTRIES];
    logic                   jal_mem    [BTB_ENTRIES];

    logic [BTB_IDX_W-1:0] rd_idx;
    logic [BTB_IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0]     rd_tag;
    logic [TAG_W-1:0]     wr_tag;
    logic [3:0]           unused_pc_bits;

    assign rd_idx = lookup_pc[BTB_IDX_W+1:2];
    assign rd_tag = lookup_pc[31:BTB_IDX_W+2];
    assign wr_idx = wr_pc[BTB_IDX_W+1:2];
    assign wr_tag = wr_pc[31:BTB_IDX_W+2];
    assign unused_pc_bits = {lookup_pc[1:0], wr_pc[1:0]};

    assign hit    = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign target = target_mem[rd_idx];
    assign is_jal = jal_mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
            jal_mem[wr_idx]    <= wr_is_jal;
        end
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// gshare direction predictor + BTB: zero-cycle IF prediction, EX-stage mispredict
// detection/redirect, and training with speculative global history repair.
module branch_predictor_gshare
    import branch_predictor_gshare_pkg::*;
#(
    parameter int BHT_IDX_W = 7,
    parameter int GHR_W     = 7,
    parameter int BTB_IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_stall,
    input  logic             halt,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             ex_valid,
    input  logic             ex_is_cond,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic [GHR_W-1:0] ex_ghr,
    output logic             ex_mispredict,
    output logic [31:0]      redirect_pc
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

    logic [GHR_W-1:0]     ghr_reg;
    logic [GHR_W-1:0]     ghr_next;
    bp_ctr_t              ctr_reg [BHT_ENTRIES];
    bp_ctr_t              if_ctr;
    logic [BHT_IDX_W-1:0] if_idx;
    logic [BHT_IDX_W-1:0] ex_idx;
    logic                 btb_hit;
    logic                 btb_is_jal;
    logic [31:0]          btb_target;
    logic [31:0]          correct_next;
    logic                 update_en;
    logic                 spec_en;
    logic                 unused_ex_pred_taken;

    // Mispredict is judged on next-PC alone, so the direction bit is informational.
    assign unused_ex_pred_taken = ex_pred_taken;

    assign if_idx = if_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_reg);
    assign ex_idx = ex_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ex_ghr);
    assign if_ctr = ctr_reg[if_idx];

    branch_predictor_gshare_btb #(
        .BTB_IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .lookup_pc (if_pc),
        .hit       (btb_hit),
        .target    (btb_target),
        .is_jal    (btb_is_jal),
        .wr_en     (update_en && ex_taken),
        .wr_pc     (ex_pc),
        .wr_target (ex_target),
        .wr_is_jal (~ex_is_cond)
    );

    assign pred_taken  = btb_hit && (if_ctr[1] || btb_is_jal);
    assign pred_target = pred_taken ? btb_target : if_pc + 32'd4;
    assign pred_ghr    = ghr_reg;

    assign correct_next  = ex_taken ? ex_target : ex_pc + 32'd4;
    assign ex_mispredict = ex_valid && (ex_pred_target != correct_next);
    assign redirect_pc   = correct_next;

    assign update_en = ex_valid && !cpu_stall && !halt;
    assign spec_en   = if_valid && !cpu_stall && !halt && btb_hit && !btb_is_jal;

    // Shifts are written as truncating casts so GHR_W=1 needs no special case.
    always_comb begin
        ghr_next = ghr_reg;
        if (update_en && ex_mispredict) begin
            ghr_next = ex_is_cond ? GHR_W'({ex_ghr, ex_taken}) : ex_ghr;
        end else if (spec_en) begin
            ghr_next = GHR_W'({ghr_reg, pred_taken});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_reg <= '0;
        end else begin
            ghr_reg <= ghr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_ctr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctr_reg[gi] <= BP_CTR_RESET;
                end else if (update_en && ex_is_cond && ex_idx == BHT_IDX_W'(gi)) begin
                    ctr_reg[gi] <= ctr_step(ctr_reg[gi], ex_taken);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed + randomized bench for branch_predictor_gshare against a table-level
// reference model of counters, BTB entries and global history.
module tb_branch_predictor_gshare;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_stall, halt, if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [6:0]  pred_ghr;
    logic        ex_valid, ex_is_cond, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic [6:0]  ex_ghr;
    logic        ex_mispredict;
    logic [31:0] redirect_pc;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: counters as 0..3 integers, BTB as plain arrays.
    int          m_ctr [128];
    bit          m_v   [32];
    logic [31:0] m_tag [32];
    logic [31:0] m_tgt [32];
    bit          m_jal [32];
    int          m_ghr;

    always #5 clk = ~clk;

    branch_predictor_gshare dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_stall      (cpu_stall),
        .halt           (halt),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_ghr       (pred_ghr),
        .ex_valid       (ex_valid),
        .ex_is_cond     (ex_is_cond),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_ghr         (ex_ghr),
        .ex_mispredict  (ex_mispredict),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_ctr[i] = 1;
        for (int i = 0; i < 32; i++) begin
            m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_jal[i] = 0;
        end
        m_ghr = 0;
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_is_cond = 1'b1; ex_pc = 32'h0; ex_taken = 1'b0;
        ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h4; ex_ghr = 7'h0;
    endtask

    task automatic ex_set(input bit cond, input logic [31:0] pc, input bit tk,
                          input logic [31:0] tgt, input logic [31:0] ptgt, input int ghr);
        ex_valid = 1'b1; ex_is_cond = cond; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_target = ptgt; ex_pred_taken = (ptgt != pc + 32'd4); ex_ghr = 7'(ghr);
    endtask

    // Check all outputs against the model, then advance one clock and train the model.
    task automatic step(input string tag);
        int          idx, bi, ui;
        bit          hit, ptk, mis, upd, spec;
        logic [31:0] ptgt, corr;
        #1;
        bi   = int'((if_pc >> 2) & 32'd31);
        hit  = m_v[bi] && (m_tag[bi] == (if_pc >> 7));
        idx  = int'((if_pc >> 2) & 32'd127) ^ m_ghr;
        ptk  = hit && (m_ctr[idx] >= 2 || m_jal[bi]);
        ptgt = ptk ? m_tgt[bi] : if_pc + 32'd4;
        corr = ex_taken ? ex_target : ex_pc + 32'd4;
        mis  = ex_valid && (ex_pred_target != corr);
        chk({tag, ".pred_taken"},  32'(pred_taken),    32'(ptk));
        chk({tag, ".pred_target"}, pred_target,        ptgt);
        chk({tag, ".pred_ghr"},    32'(pred_ghr),      32'(m_ghr));
        chk({tag, ".mispredict"},  32'(ex_mispredict), 32'(mis));
        chk({tag, ".redirect"},    redirect_pc,        corr);
        $display("step %-10s if_pc=%h pt=%0d tgt=%h ghr=%h | ex_v=%0d pc=%h mis=%0d redir=%h",
                 tag, if_pc, pred_taken, pred_target, pred_ghr, ex_valid, ex_pc, ex_mispredict, redirect_pc);
        upd  = ex_valid && !cpu_stall && !halt;
        spec = if_valid && !cpu_stall && !halt && hit && !m_jal[bi];
        @(posedge clk);
        if (upd && ex_is_cond) begin
            ui = int'((ex_pc >> 2) & 32'd127) ^ int'(ex_ghr);
            if (ex_taken) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
            else          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
        if (upd && ex_taken) begin
            ui = int'((ex_pc >> 2) & 32'd31);
            m_v[ui] = 1; m_tag[ui] = ex_pc >> 7; m_tgt[ui] = ex_target; m_jal[ui] = !ex_is_cond;
        end
        if (upd && mis) m_ghr = ex_is_cond ? (((int'(ex_ghr) << 1) | int'(ex_taken)) & 127) : int'(ex_ghr);
        else if (spec)  m_ghr = ((m_ghr << 1) | int'(ptk)) & 127;
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; cpu_stall = 1'b0; halt = 1'b0; if_valid = 1'b0; if_pc = 32'h100;
        ex_idle();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset state
        #1;
        chk("reset.pred_taken",  32'(pred_taken),    32'h0);
        chk("reset.pred_target", pred_target,        32'h104);
        chk("reset.pred_ghr",    32'(pred_ghr),      32'h0);
        chk("reset.mispredict",  32'(ex_mispredict), 32'h0);
        step("reset");

        // Two correctly predicted taken branches train counter WNT->ST and fill BTB
        ex_set(1, 32'h100, 1, 32'h80, 32'h80, 0);
        step("train1");
        step("train2");
        ex_idle(); if_pc = 32'h100;
        #1;
        chk("trained.pred_taken",  32'(pred_taken), 32'h1);
        chk("trained.pred_target", pred_target,     32'h80);
        step("trained");

        // Conditional mispredict restores GHR from ex_ghr, beating a concurrent IF shift
        if_valid = 1'b1; if_pc = 32'h100;
        ex_set(1, 32'h100, 0, 32'h80, 32'h80, 7'h05);
        #1;
        chk("mispred.flag",     32'(ex_mispredict), 32'h1);
        chk("mispred.redirect", redirect_pc,        32'h104);
        step("mispred");
        if_valid = 1'b0; ex_idle();
        #1;
        chk("mispred.ghr_restore", 32'(pred_ghr), 32'h0A);
        step("post_mis");

        // Stall and halt block every state update while the flag still fires
        ex_set(1, 32'h100, 0, 32'h80, 32'h80, 7'h05);
        cpu_stall = 1'b1; if_valid = 1'b1;
        #1;
        chk("stall.flag", 32'(ex_mispredict), 32'h1);
        step("stall");
        cpu_stall = 1'b0; halt = 1'b1;
        step("halt");
        halt = 1'b0; if_valid = 1'b0; ex_idle();
        #1;
        chk("stall.ghr_kept", 32'(pred_ghr), 32'h0A);
        step("post_stall");

        // Counter hysteresis: ST -> WT still taken, WT -> WNT not taken
        for (int i = 0; i < 4; i++) begin
            ex_set(1, 32'h300, 1, 32'h40, 32'h40, m_ghr);
            step("hyst_t");
        end
        ex_set(1, 32'h300, 0, 32'h40, 32'h304, m_ghr);
        step("hyst_nt1");
        ex_idle(); if_pc = 32'h300;
        #1;
        chk("hyst.wt_taken", 32'(pred_taken), 32'h1);
        step("hyst_q1");
        ex_set(1, 32'h300, 0, 32'h40, 32'h304, m_ghr);
        step("hyst_nt2");
        ex_idle(); if_pc = 32'h300;
        #1;
        chk("hyst.wnt_not_taken", 32'(pred_taken), 32'h0);
        step("hyst_q2");

        // JAL installs an always-taken BTB entry
        ex_set(0, 32'h200, 1, 32'h400, 32'h204, m_ghr);
        step("jal");
        ex_idle(); if_pc = 32'h200; if_valid = 1'b1;
        #1;
        chk("jal.pred_taken",  32'(pred_taken), 32'h1);
        chk("jal.pred_target", pred_target,     32'h400);
        step("jal_q");

        // Randomized traffic against the model, with one reset in the middle
        for (int i = 0; i < 300; i++) begin
            logic [31:0] corr;
            if (i == 150) reset_pulse();
            if_valid   = 1'($urandom_range(0, 1));
            if_pc      = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 255)) << 2);
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_is_cond = ($urandom_range(0, 3) != 0);
            ex_pc      = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 255)) << 2);
            ex_taken   = ex_is_cond ? 1'($urandom_range(0, 1)) : 1'b1;
            ex_target  = 32'($urandom_range(0, 1023)) << 2;
            corr       = ex_taken ? ex_target : ex_pc + 32'd4;
            ex_pred_target = ($urandom_range(0, 2) == 0) ? (32'($urandom_range(0, 1023)) << 2) : corr;
            ex_pred_taken  = (ex_pred_target != ex_pc + 32'd4);
            ex_ghr     = ($urandom_range(0, 1) == 0) ? 7'(m_ghr) : 7'($urandom_range(0, 127));
            cpu_stall  = ($urandom_range(0, 7) == 0);
            halt       = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        // Reset mid-run returns to the power-on state
        cpu_stall = 1'b0; halt = 1'b0; if_valid = 1'b0; if_pc = 32'h100; ex_idle();
        reset_pulse();
        #1;
        chk("rst2.pred_taken",  32'(pred_taken),    32'h0);
        chk("rst2.pred_target", pred_target,        32'h104);
        chk("rst2.pred_ghr",    32'(pred_ghr),      32'h0);
        chk("rst2.mispredict",  32'(ex_mispredict), 32'h0);
        step("rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
